// File: rtl/mips_memory_if.sv
//------------------------------------------------------------------------------
// mips_memory_if : fetch, load/store, preload and status signals of mips_memory
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mips_memory_if;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        data_rd_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        mem_ready;
  logic        fault;
  logic [31:0] fault_addr;
  logic        fault_is_instr;

  modport master (
    output instr_addr, data_rd_wr, data_addr, data_wdata,
           load_valid, load_addr, load_data,
    input  instr_data, data_rdata, load_ready, mem_ready,
           fault, fault_addr, fault_is_instr
  );

  modport slave (
    input  instr_addr, data_rd_wr, data_addr, data_wdata,
           load_valid, load_addr, load_data,
    output instr_data, data_rdata, load_ready, mem_ready,
           fault, fault_addr, fault_is_instr
  );
endinterface

`default_nettype wire

// File: rtl/mips_memory.sv
//------------------------------------------------------------------------------
// mips_memory : self-clearing word memory serving the mips fetch and data ports
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic          clk,
  input  logic          reset,
  mips_memory_if.slave  bus
);

  localparam int              IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0]     MEM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      instr_data_q;
  logic [31:0]      data_rdata_q;
  logic             mem_ready_q;
  logic             fault_q;
  logic [31:0]      fault_addr_q;
  logic             fault_is_instr_q;

  logic [31:0]      i_off, d_off, l_off;
  logic             i_legal, d_legal, l_legal;
  logic [IDX_W-1:0] i_idx, d_idx, l_idx;
  logic             store_legal;
  logic             load_ready;

  // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land out of range.
  assign i_off   = bus.instr_addr - BASE_ADDR;
  assign d_off   = bus.data_addr  - BASE_ADDR;
  assign l_off   = bus.load_addr  - BASE_ADDR;
  assign i_legal = (bus.instr_addr[1:0] == 2'b00) && ({1'b0, i_off} < MEM_BYTES);
  assign d_legal = (bus.data_addr[1:0]  == 2'b00) && ({1'b0, d_off} < MEM_BYTES);
  assign l_legal = (bus.load_addr[1:0]  == 2'b00) && ({1'b0, l_off} < MEM_BYTES);
  assign i_idx   = i_off[IDX_W+1:2];
  assign d_idx   = d_off[IDX_W+1:2];
  assign l_idx   = l_off[IDX_W+1:2];

  assign store_legal = !bus.data_rd_wr && d_legal;
  assign load_ready  = (state_q == S_READY) && !store_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_CLEAR;
      clr_idx_q        <= '0;
      instr_data_q     <= '0;
      data_rdata_q     <= '0;
      mem_ready_q      <= 1'b0;
      fault_q          <= 1'b0;
      fault_addr_q     <= '0;
      fault_is_instr_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          instr_data_q     <= '0;
          data_rdata_q     <= '0;
          mem_q[clr_idx_q] <= '0;
          if (clr_idx_q == LAST_IDX) begin
            state_q     <= S_READY;
            mem_ready_q <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        S_READY: begin
          instr_data_q <= i_legal ? mem_q[i_idx] : '0;
          data_rdata_q <= d_legal ? mem_q[d_idx] : '0;
          if (store_legal)
            mem_q[d_idx] <= bus.data_wdata;
          // Illegal preload addresses are accepted and silently dropped.
          if (bus.load_valid && load_ready && l_legal)
            mem_q[l_idx] <= bus.load_data;
          if (!fault_q) begin
            if (!d_legal) begin
              fault_q          <= 1'b1;
              fault_addr_q     <= bus.data_addr;
              fault_is_instr_q <= 1'b0;
            end else if (!i_legal) begin
              fault_q          <= 1'b1;
              fault_addr_q     <= bus.instr_addr;
              fault_is_instr_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= S_CLEAR;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  assign bus.instr_data     = instr_data_q;
  assign bus.data_rdata     = data_rdata_q;
  assign bus.load_ready     = load_ready;
  assign bus.mem_ready      = mem_ready_q;
  assign bus.fault          = fault_q;
  assign bus.fault_addr     = fault_addr_q;
  assign bus.fault_is_instr = fault_is_instr_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_memory.sv
//------------------------------------------------------------------------------
// tb_mips_memory : directed self-checking bench for mips_memory (16 words)
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_memory;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  mips_memory_if bus ();

  mips_memory #(
    .BASE_ADDR   (32'h0000_0000),
    .DEPTH_WORDS (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.instr_addr = 32'h0;
    bus.data_rd_wr = 1'b1;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    bus.load_valid = 1'b0;
    bus.load_addr  = 32'h0;
    bus.load_data  = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    tick();
    n_vec++; if (bus.instr_data !== 32'h0) begin n_err++; $display("FAIL rst_instr_data got %h want 0", bus.instr_data); end
    n_vec++; if (bus.data_rdata !== 32'h0) begin n_err++; $display("FAIL rst_data_rdata got %h want 0", bus.data_rdata); end
    n_vec++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL rst_load_ready got %b want 0", bus.load_ready); end
    n_vec++; if (bus.mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_mem_ready got %b want 0", bus.mem_ready); end
    n_vec++; if (bus.fault !== 1'b0 || bus.fault_addr !== 32'h0 || bus.fault_is_instr !== 1'b0) begin
      n_err++; $display("FAIL rst_fault got %b/%h/%b want 0/0/0", bus.fault, bus.fault_addr, bus.fault_is_instr);
    end
  endtask

  task automatic test_clear_sweep;
    reset = 1'b0;
    bus.instr_addr = 32'h3C;
    for (int e = 1; e <= 16; e++) begin
      tick();
      n_vec++;
      if (bus.mem_ready !== (e == 16)) begin
        n_err++; $display("FAIL sweep_mem_ready edge %0d got %b want %b", e, bus.mem_ready, (e == 16));
      end
      if (e == 8) begin
        n_vec++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL sweep_load_ready got %b want 0", bus.load_ready); end
      end
    end
    tick();
    n_vec++; if (bus.instr_data !== 32'h0) begin n_err++; $display("FAIL sweep_instr_3c got %h want 0", bus.instr_data); end
    n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL sweep_fault got %b want 0", bus.fault); end
  endtask

  task automatic test_reset_mid_clear;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    reset = 1'b1;
    tick();
    n_vec++; if (bus.mem_ready !== 1'b0) begin n_err++; $display("FAIL midclr_reset got %b want 0", bus.mem_ready); end
    reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      n_vec++;
      if (bus.mem_ready !== (e == 16)) begin
        n_err++; $display("FAIL midclr_mem_ready edge %0d got %b want %b", e, bus.mem_ready, (e == 16));
      end
    end
  endtask

  task automatic test_preload;
    bus.instr_addr = 32'h0;
    bus.data_rd_wr = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_addr  = 32'h0;
    bus.load_data  = 32'h2408_0005;
    #1;
    n_vec++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL pre_ready0 got %b want 1", bus.load_ready); end
    tick();
    bus.load_addr = 32'h4;
    bus.load_data = 32'h2509_FFFF;
    #1;
    n_vec++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL pre_ready1 got %b want 1", bus.load_ready); end
    tick();
    bus.load_valid = 1'b0;
    bus.instr_addr = 32'h4;
    tick();
    n_vec++; if (bus.instr_data !== 32'h2509_FFFF) begin n_err++; $display("FAIL pre_fetch4 got %h want 2509ffff", bus.instr_data); end
    bus.instr_addr = 32'h0;
    tick();
    n_vec++; if (bus.instr_data !== 32'h2408_0005) begin n_err++; $display("FAIL pre_fetch0 got %h want 24080005", bus.instr_data); end
  endtask

  task automatic test_store_load;
    bus.data_rd_wr = 1'b0;
    bus.data_addr  = 32'h20;
    bus.data_wdata = 32'hDEAD_BEEF;
    bus.instr_addr = 32'h20;
    tick();
    n_vec++; if (bus.data_rdata !== 32'h0) begin n_err++; $display("FAIL rbw_old got %h want 0", bus.data_rdata); end
    n_vec++; if (bus.instr_data !== 32'h0) begin n_err++; $display("FAIL rbw_instr_old got %h want 0", bus.instr_data); end
    bus.data_rd_wr = 1'b1;
    tick();
    n_vec++; if (bus.data_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rbw_new got %h want deadbeef", bus.data_rdata); end
    n_vec++; if (bus.instr_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rbw_instr_new got %h want deadbeef", bus.instr_data); end
  endtask

  task automatic test_store_vs_preload;
    bus.instr_addr = 32'h0;
    bus.data_rd_wr = 1'b0;
    bus.data_addr  = 32'h8;
    bus.data_wdata = 32'h1111_1111;
    bus.load_valid = 1'b1;
    bus.load_addr  = 32'h8;
    bus.load_data  = 32'h2222_2222;
    #1;
    n_vec++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL coll_ready_store got %b want 0", bus.load_ready); end
    tick();
    bus.data_rd_wr = 1'b1;
    #1;
    n_vec++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL coll_ready_read got %b want 1", bus.load_ready); end
    tick();
    n_vec++; if (bus.data_rdata !== 32'h1111_1111) begin n_err++; $display("FAIL coll_store_landed got %h want 11111111", bus.data_rdata); end
    bus.load_valid = 1'b0;
    tick();
    n_vec++; if (bus.data_rdata !== 32'h2222_2222) begin n_err++; $display("FAIL coll_load_landed got %h want 22222222", bus.data_rdata); end
  endtask

  task automatic test_faults;
    logic [31:0] exp_mem [16];
    bus.data_rd_wr = 1'b1;
    bus.data_addr  = 32'h41;
    bus.instr_addr = 32'h0;
    tick();
    n_vec++; if (bus.data_rdata !== 32'h0) begin n_err++; $display("FAIL flt_rdata got %h want 0", bus.data_rdata); end
    n_vec++; if (bus.fault !== 1'b1 || bus.fault_addr !== 32'h41 || bus.fault_is_instr !== 1'b0) begin
      n_err++; $display("FAIL flt_first got %b/%h/%b want 1/41/0", bus.fault, bus.fault_addr, bus.fault_is_instr);
    end
    bus.data_addr  = 32'h0;
    bus.instr_addr = 32'h1000;
    tick();
    n_vec++; if (bus.instr_data !== 32'h0) begin n_err++; $display("FAIL flt_instr_data got %h want 0", bus.instr_data); end
    n_vec++; if (bus.fault !== 1'b1 || bus.fault_addr !== 32'h41 || bus.fault_is_instr !== 1'b0) begin
      n_err++; $display("FAIL flt_sticky got %b/%h/%b want 1/41/0", bus.fault, bus.fault_addr, bus.fault_is_instr);
    end
    bus.instr_addr = 32'h0;
    bus.data_rd_wr = 1'b0;
    bus.data_addr  = 32'h40;
    bus.data_wdata = 32'hFFFF_FFFF;
    tick();
    n_vec++; if (bus.data_rdata !== 32'h0) begin n_err++; $display("FAIL flt_oor_rdata got %h want 0", bus.data_rdata); end
    bus.data_rd_wr = 1'b1;
    bus.data_addr  = 32'h0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
    exp_mem[0] = 32'h2408_0005;
    exp_mem[1] = 32'h2509_FFFF;
    exp_mem[2] = 32'h2222_2222;
    exp_mem[8] = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) begin
      bus.instr_addr = 32'(i * 4);
      tick();
      n_vec++;
      if (bus.instr_data !== exp_mem[i]) begin
        n_err++; $display("FAIL flt_mem_word %0d got %h want %h", i, bus.instr_data, exp_mem[i]);
      end
    end
  endtask

  task automatic test_simultaneous_fault;
    int cyc;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
    while (bus.mem_ready !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_vec++; if (bus.mem_ready !== 1'b1) begin n_err++; $display("FAIL sim_clear_timeout got %b want 1", bus.mem_ready); end
    n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL sim_fault_cleared got %b want 0", bus.fault); end
    bus.instr_addr = 32'h2;
    bus.data_rd_wr = 1'b1;
    bus.data_addr  = 32'h44;
    tick();
    n_vec++; if (bus.fault !== 1'b1 || bus.fault_addr !== 32'h44 || bus.fault_is_instr !== 1'b0) begin
      n_err++; $display("FAIL sim_data_wins got %b/%h/%b want 1/44/0", bus.fault, bus.fault_addr, bus.fault_is_instr);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_clear_sweep();
    test_reset_mid_clear();
    test_preload();
    test_store_load();
    test_store_vs_preload();
    test_faults();
    test_simultaneous_fault();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_memory.md
Name: mips_memory

Overview:
- Word-organised memory model that services both memory interfaces of the mips core: the instruction-fetch port and the data load/store port.
- Clears itself after reset, then accepts a program/data preload over a valid/ready load port.
- Responds to processor reads and writes with one-cycle registered read data.
- Records the first illegal access (out of range or misaligned) for the testbench and debug.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.
- DEPTH_WORDS, 1024, number of 32-bit words; must be ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- instr_addr  input  32  byte address of the instruction fetch.
- instr_data  output  32  registered fetched word.
- data_rd_wr  input  1  1 = read, 0 = write.
- data_addr  input  32  byte address of the data access.
- data_wdata  input  32  store data from the core.
- data_rdata  output  32  registered load data to the core.
- load_valid  input  1  preload word offered.
- load_ready  output  1  preload word accepted this cycle when valid.
- load_addr  input  32  preload byte address.
- load_data  input  32  preload word.
- mem_ready  output  1  clear sweep complete; memory in service.
- fault  output  1  sticky illegal-access flag.
- fault_addr  output  32  byte address of the first illegal access.
- fault_is_instr  output  1  1 if the first fault came from the instruction port.

Behaviour:
- Reset values: instr_data=0, data_rdata=0, load_ready=0, mem_ready=0, fault=0, fault_addr=0, fault_is_instr=0. State=CLEAR, clear index=0.
- States:
  - CLEAR: each non-reset edge writes mem[idx]=0 and increments idx.
  - Edge writing idx=DEPTH_WORDS-1: state->READY and mem_ready<=1. mem_ready is therefore high after the DEPTH_WORDS-th edge following reset release.
  - READY: normal service; left only by reset.
  - Reset asserted in any state, including mid-clear: returns to CLEAR with idx=0. Memory contents are not otherwise preserved.
- Address decode, per port:
  - off = addr - BASE_ADDR (32-bit unsigned, wraps).
  - Legal iff addr[1:0]==0 and off < DEPTH_WORDS*4.
  - Word index = off>>2.
- During CLEAR:
  - instr_data and data_rdata are driven 0 each cycle.
  - CPU writes are ignored and no faults are recorded.
  - load_ready=0.
- Instruction port (READY): every edge, instr_data <= legal ? mem[idx] : 0. Latency 1 cycle, no enable.
- Data read (READY, data_rd_wr=1): every edge, data_rdata <= legal ? mem[idx] : 0.
- Data write (READY, data_rd_wr=0):
  - Legal address: mem[idx] <= data_wdata. data_rdata <= old mem[idx] (read-before-write).
  - Illegal address: write suppressed.
- Same-cycle collisions:
  - Instruction read of a word written the same cycle returns the old value; new value is visible the next cycle.
- Load port:
  - load_ready = (state==READY) && !(data_rd_wr==0 && data address legal). The CPU store has priority; load_ready is combinational from these.
  - Transfer when load_valid && load_ready: legal load_addr writes mem; illegal load_addr is dropped, sets no fault, but is still accepted.
  - load_data/load_addr must be held stable while valid && !ready.
- Fault capture (READY only):
  - Illegal instruction or data access sets fault=1 on that edge.
  - fault_addr and fault_is_instr are captured only if fault was 0.
  - Data and instruction fault in the same cycle: data wins (fault_is_instr=0).
  - Fault is sticky until reset. Faulting accesses still complete per the rules above.
- Width rules: no byte enables; all accesses are full 32-bit words. DEPTH_WORDS*4 is computed in 33 bits to avoid overflow.

Test Plan:
- Clear sweep: DEPTH_WORDS=16, reset 1 cycle, release -> mem_ready low 15 edges, high after 16th; instr_addr=0x3C reads 0; fault=0. Reset again at edge 5 -> sweep restarts, mem_ready after 16 further edges.
- Preload: load word 0x24080005 to 0x0 and 0x2509FFFF to 0x4 with load_valid held -> accepted one per cycle. instr_addr=0x4 gives instr_data=0x2509FFFF one cycle later.
- Store/load and read-before-write:
  - data_rd_wr=0, data_addr=0x20, data_wdata=0xDEADBEEF over old 0x0 -> data_rdata=0x0 next cycle.
  - Following read of 0x20 -> 0xDEADBEEF.
  - Concurrent instr_addr=0x20 on the write cycle -> old value.
- Store vs preload collision: CPU store to legal 0x8 while load_valid=1 -> load_ready=0 that cycle, store lands. Load accepted the next cycle when data_rd_wr=1 and overwrites 0x8.
- Faults:
  - data read 0x41 -> data_rdata=0, fault=1, fault_addr=0x41, fault_is_instr=0.
  - Later instr_addr=0x1000 -> fault stays, fault_addr unchanged.
  - Store to 0x40 (out of range) leaves all words unchanged.
- Simultaneous fault: fresh reset+clear, same cycle instr_addr=0x2 and data_addr=0x44 (read) -> fault_addr=0x44, fault_is_instr=0.
